fat32_volume_id_parser: RTL and testbench

- Sits beside fat32_controller, downstream of sd_card_controller's read data stream.
- Consumes the 512-byte FAT32 Volume ID sector, byte by byte, and extracts the BPB fields.
- Validates the fields and computes fat_begin_lba and cluster_begin_lba for the cluster/FAT walkers that follow.
- Has no SD command logic; it only observes the byte/block strobes.

---
 rtl/fat32_volume_id_parser_pkg.sv | 44 ++++
 rtl/fat32_volume_id_parser_if.sv | 37 +++
 rtl/fat32_volume_id_parser.sv | 135 +++++++++++++
 tb/tb_fat32_volume_id_parser.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fat32_volume_id_parser_pkg.sv
// Shared definitions for the FAT32 Volume ID parser: FSM encodings, BPB byte
// offsets, error codes and the boot-sector signature bytes.
package fat32_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_CHECK   = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [9:0] OFF_BPS_LO  = 10'd11;
  localparam logic [9:0] OFF_BPS_HI  = 10'd12;
  localparam logic [9:0] OFF_SPC     = 10'd13;
  localparam logic [9:0] OFF_RSV_LO  = 10'd14;
  localparam logic [9:0] OFF_RSV_HI  = 10'd15;
  localparam logic [9:0] OFF_NFATS   = 10'd16;
  localparam logic [9:0] OFF_SPF_0   = 10'd36;
  localparam logic [9:0] OFF_SPF_1   = 10'd37;
  localparam logic [9:0] OFF_SPF_2   = 10'd38;
  localparam logic [9:0] OFF_SPF_3   = 10'd39;
  localparam logic [9:0] OFF_ROOT_0  = 10'd44;
  localparam logic [9:0] OFF_ROOT_1  = 10'd45;
  localparam logic [9:0] OFF_ROOT_2  = 10'd46;
  localparam logic [9:0] OFF_ROOT_3  = 10'd47;
  localparam logic [9:0] OFF_SIG_LO  = 10'd510;
  localparam logic [9:0] OFF_SIG_HI  = 10'd511;

  localparam logic [7:0] SIG_LO = 8'h55;
  localparam logic [7:0] SIG_HI = 8'hAA;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_BPS   = 3'd1;
  localparam logic [2:0] ERR_SPC   = 3'd2;
  localparam logic [2:0] ERR_NFATS = 3'd3;
  localparam logic [2:0] ERR_SIG   = 3'd4;
  localparam logic [2:0] ERR_COUNT = 3'd5;

  function automatic logic is_pow2(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/fat32_volume_id_parser_if.sv
// Byte-stream input and BPB result bundle between the SD read path and the parser.
interface fat32_volume_id_parser_if;
  // Strobe semantics: start, byte_valid and block_done are single-cycle pulses
  // with no back-pressure; done is a one-cycle pulse, valid/error are levels.
  logic        start;
  logic [31:0] partition_lba_begin;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        block_done;
  logic        busy;
  logic        done;
  logic        valid;
  logic        error;
  logic [2:0]  error_code;
  logic [15:0] bytes_per_sector;
  logic [7:0]  sectors_per_cluster;
  logic [15:0] reserved_sectors;
  logic [7:0]  num_fats;
  logic [31:0] sectors_per_fat;
  logic [31:0] root_cluster;
  logic [31:0] fat_begin_lba;
  logic [31:0] cluster_begin_lba;

  modport master (
    output start, partition_lba_begin, byte_in, byte_valid, block_done,
    input  busy, done, valid, error, error_code, bytes_per_sector,
           sectors_per_cluster, reserved_sectors, num_fats, sectors_per_fat,
           root_cluster, fat_begin_lba, cluster_begin_lba
  );

  modport slave (
    input  start, partition_lba_begin, byte_in, byte_valid, block_done,
    output busy, done, valid, error, error_code, bytes_per_sector,
           sectors_per_cluster, reserved_sectors, num_fats, sectors_per_fat,
           root_cluster, fat_begin_lba, cluster_begin_lba
  );
endinterface

// File: rtl/fat32_volume_id_parser.sv
// Captures the FAT32 Volume ID sector, validates the BPB and derives the FAT and
// cluster-region start LBAs with one 32-bit add per FAT copy.
module fat32_volume_id_parser
  import fat32_pkg::*;
#(
  parameter int SECTOR_BYTES = 512,
  parameter int MAX_FATS     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fat32_volume_id_parser_if.slave  bus,
  output state_t                   o_state
);

  state_t      r_state, w_state_next;
  logic [2:0]  w_check_code;
  logic [31:0] r_part;
  logic [9:0]  r_byte_cnt;
  logic        r_overflow;
  logic [7:0]  r_sig_lo, r_sig_hi;
  logic [15:0] r_bps, r_rsv;
  logic [7:0]  r_spc, r_nfats, r_fat_cnt;
  logic [31:0] r_spf, r_root, r_fat_begin, r_cluster_begin;
  logic        r_busy, r_done, r_valid, r_error;
  logic [2:0]  r_error_code;

  always_comb begin
    w_state_next = r_state;
    w_check_code = ERR_NONE;
    // First failing check wins.
    if (r_byte_cnt != 10'(SECTOR_BYTES) || r_overflow) w_check_code = ERR_COUNT;
    else if (r_bps != 16'(SECTOR_BYTES))                w_check_code = ERR_BPS;
    else if (!is_pow2(r_spc))                           w_check_code = ERR_SPC;
    else if (r_nfats == 8'd0 || r_nfats > 8'(MAX_FATS)) w_check_code = ERR_NFATS;
    else if (r_sig_lo != SIG_LO || r_sig_hi != SIG_HI)  w_check_code = ERR_SIG;
    case (r_state)
      ST_IDLE:    if (bus.start) w_state_next = ST_CAPTURE;
      ST_CAPTURE: if (bus.block_done) w_state_next = ST_CHECK;
      ST_CHECK:   w_state_next = (w_check_code != ERR_NONE) ? ST_DONE : ST_COMPUTE;
      ST_COMPUTE: if (r_fat_cnt <= 8'd1) w_state_next = ST_DONE;
      ST_DONE:    w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_part <= '0; r_byte_cnt <= '0; r_overflow <= 1'b0;
      r_sig_lo <= '0; r_sig_hi <= '0;
      r_bps <= '0; r_spc <= '0; r_rsv <= '0; r_nfats <= '0;
      r_spf <= '0; r_root <= '0; r_fat_begin <= '0; r_cluster_begin <= '0;
      r_fat_cnt <= '0; r_busy <= 1'b0; r_done <= 1'b0; r_valid <= 1'b0;
      r_error <= 1'b0; r_error_code <= ERR_NONE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start) begin
          r_part <= bus.partition_lba_begin;
          r_byte_cnt <= '0; r_overflow <= 1'b0;
          r_sig_lo <= '0; r_sig_hi <= '0;
          r_bps <= '0; r_spc <= '0; r_rsv <= '0; r_nfats <= '0;
          r_spf <= '0; r_root <= '0; r_fat_begin <= '0; r_cluster_begin <= '0;
          r_fat_cnt <= '0; r_valid <= 1'b0; r_error <= 1'b0;
          r_error_code <= ERR_NONE; r_busy <= 1'b1;
        end
        ST_CAPTURE: if (bus.byte_valid) begin
          if (r_byte_cnt == 10'(SECTOR_BYTES)) begin
            r_overflow <= 1'b1;
          end else begin
            r_byte_cnt <= r_byte_cnt + 10'd1;
            case (r_byte_cnt)
              OFF_BPS_LO: r_bps[7:0]    <= bus.byte_in;
              OFF_BPS_HI: r_bps[15:8]   <= bus.byte_in;
              OFF_SPC:    r_spc         <= bus.byte_in;
              OFF_RSV_LO: r_rsv[7:0]    <= bus.byte_in;
              OFF_RSV_HI: r_rsv[15:8]   <= bus.byte_in;
              OFF_NFATS:  r_nfats       <= bus.byte_in;
              OFF_SPF_0:  r_spf[7:0]    <= bus.byte_in;
              OFF_SPF_1:  r_spf[15:8]   <= bus.byte_in;
              OFF_SPF_2:  r_spf[23:16]  <= bus.byte_in;
              OFF_SPF_3:  r_spf[31:24]  <= bus.byte_in;
              OFF_ROOT_0: r_root[7:0]   <= bus.byte_in;
              OFF_ROOT_1: r_root[15:8]  <= bus.byte_in;
              OFF_ROOT_2: r_root[23:16] <= bus.byte_in;
              OFF_ROOT_3: r_root[31:24] <= bus.byte_in;
              OFF_SIG_LO: r_sig_lo      <= bus.byte_in;
              OFF_SIG_HI: r_sig_hi      <= bus.byte_in;
              default: ;
            endcase
          end
        end
        ST_CHECK: begin
          if (w_check_code != ERR_NONE) begin
            r_error <= 1'b1; r_error_code <= w_check_code;
            r_busy <= 1'b0; r_done <= 1'b1;
          end else begin
            r_fat_begin     <= r_part + {16'd0, r_rsv};
            r_cluster_begin <= r_part + {16'd0, r_rsv};
            r_fat_cnt       <= r_nfats;
          end
        end
        ST_COMPUTE: begin
          // Repeated add replaces num_fats * sectors_per_fat.
          r_cluster_begin <= r_cluster_begin + r_spf;
          r_fat_cnt       <= r_fat_cnt - 8'd1;
          if (r_fat_cnt <= 8'd1) begin
            r_valid <= 1'b1; r_busy <= 1'b0; r_done <= 1'b1;
          end
        end
        ST_DONE: r_done <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_state                 = r_state;
  assign bus.busy                = r_busy;
  assign bus.done                = r_done;
  assign bus.valid               = r_valid;
  assign bus.error               = r_error;
  assign bus.error_code          = r_error_code;
  assign bus.bytes_per_sector    = r_bps;
  assign bus.sectors_per_cluster = r_spc;
  assign bus.reserved_sectors    = r_rsv;
  assign bus.num_fats            = r_nfats;
  assign bus.sectors_per_fat     = r_spf;
  assign bus.root_cluster        = r_root;
  assign bus.fat_begin_lba       = r_fat_begin;
  assign bus.cluster_begin_lba   = r_cluster_begin;

endmodule

// File: tb/tb_fat32_volume_id_parser.sv
// Scoreboarded bench for the FAT32 Volume ID parser using hand-computed sectors.
module tb_fat32_volume_id_parser;
  import fat32_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t state_dbg;

  fat32_volume_id_parser_if bus();

  fat32_volume_id_parser #(.SECTOR_BYTES(512), .MAX_FATS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int neg_cnt = 0;
  always @(negedge clk) neg_cnt++;

  int checks = 0;
  int failures = 0;
  int bd_ref = 0;

  typedef struct packed {
    logic        valid;
    logic        error;
    logic [2:0]  code;
    logic [15:0] bps;
    logic [7:0]  spc;
    logic [15:0] rsv;
    logic [7:0]  nf;
    logic [31:0] spf;
    logic [31:0] root;
    logic [31:0] fat;
    logic [31:0] clus;
    logic [7:0]  lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic last_done = 1'b0;
  logic [7:0] sec [512];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic v, input logic e, input logic [2:0] c,
                                  input logic [15:0] bps, input logic [7:0] spc,
                                  input logic [15:0] rsv, input logic [7:0] nf,
                                  input logic [31:0] spf, input logic [31:0] root,
                                  input logic [31:0] fat, input logic [31:0] clus,
                                  input logic [7:0] lat);
    exp_t x;
    x.valid = v; x.error = e; x.code = c; x.bps = bps; x.spc = spc; x.rsv = rsv;
    x.nf = nf; x.spf = spf; x.root = root; x.fat = fat; x.clus = clus; x.lat = lat;
    return x;
  endfunction

  // driver tasks
  task automatic build(input logic [15:0] bps, input logic [7:0] spc, input logic [15:0] rsv,
                       input logic [7:0] nf, input logic [31:0] spf, input logic [31:0] root,
                       input logic [7:0] s1);
    for (int i = 0; i < 512; i++) sec[i] = 8'((i * 7) + 3);
    sec[11] = bps[7:0];  sec[12] = bps[15:8];
    sec[13] = spc;
    sec[14] = rsv[7:0];  sec[15] = rsv[15:8];
    sec[16] = nf;
    sec[36] = spf[7:0];  sec[37] = spf[15:8];  sec[38] = spf[23:16];  sec[39] = spf[31:24];
    sec[44] = root[7:0]; sec[45] = root[15:8]; sec[46] = root[23:16]; sec[47] = root[31:24];
    sec[510] = 8'h55;
    sec[511] = s1;
  endtask

  task automatic drive(input logic [31:0] part, input int nbytes, input bit coincide,
                       input bit pulse_start);
    @(posedge clk);
    bus.start = 1'b1; bus.partition_lba_begin = part;
    @(posedge clk);
    bus.start = 1'b0; bus.partition_lba_begin = 32'hDEAD_BEEF;
    for (int i = 0; i < nbytes; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        bus.byte_valid = 1'b0; bus.start = 1'b0;
      end
      @(posedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_in    = (i < 512) ? sec[i] : 8'hEE;
      bus.start      = pulse_start && (i == 100);
      if (coincide && i == nbytes - 1) begin
        bus.block_done = 1'b1; bd_ref = neg_cnt;
      end
    end
    if (!coincide) begin
      @(posedge clk);
      bus.byte_valid = 1'b0; bus.start = 1'b0;
      bus.block_done = 1'b1; bd_ref = neg_cnt;
    end
    @(posedge clk);
    bus.byte_valid = 1'b0; bus.block_done = 1'b0; bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout actual=pending expected=done_within_100_cycles", name);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"},  32'(state_dbg), 32'(ST_IDLE));
    check({tag, "_busy"},   32'(bus.busy), 32'd0);
    check({tag, "_done"},   32'(bus.done), 32'd0);
    check({tag, "_valid"},  32'(bus.valid), 32'd0);
    check({tag, "_error"},  32'(bus.error), 32'd0);
    check({tag, "_code"},   32'(bus.error_code), 32'd0);
    check({tag, "_bps"},    32'(bus.bytes_per_sector), 32'd0);
    check({tag, "_spf"},    bus.sectors_per_fat, 32'd0);
    check({tag, "_fat"},    bus.fat_begin_lba, 32'd0);
    check({tag, "_clus"},   bus.cluster_begin_lba, 32'd0);
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    if (last_done) check("done_one_cycle", 32'(bus.done), 32'd0);
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done actual=done expected=no_done");
      end else begin
        mon_e = exp_q.pop_front();
        check("valid",       32'(bus.valid), 32'(mon_e.valid));
        check("error",       32'(bus.error), 32'(mon_e.error));
        check("error_code",  32'(bus.error_code), 32'(mon_e.code));
        check("bps",         32'(bus.bytes_per_sector), 32'(mon_e.bps));
        check("spc",         32'(bus.sectors_per_cluster), 32'(mon_e.spc));
        check("reserved",    32'(bus.reserved_sectors), 32'(mon_e.rsv));
        check("num_fats",    32'(bus.num_fats), 32'(mon_e.nf));
        check("spf",         bus.sectors_per_fat, mon_e.spf);
        check("root",        bus.root_cluster, mon_e.root);
        check("fat_begin",   bus.fat_begin_lba, mon_e.fat);
        check("clus_begin",  bus.cluster_begin_lba, mon_e.clus);
        check("latency",     32'(neg_cnt - bd_ref), 32'(mon_e.lat));
        check("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
    last_done = rst_n && bus.done;
  end

  initial begin
    bus.start = 1'b0; bus.partition_lba_begin = '0; bus.byte_in = '0;
    bus.byte_valid = 1'b0; bus.block_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset");
    @(posedge clk);
    rst_n = 1'b1;

    // strobes in IDLE are ignored
    @(posedge clk);
    bus.byte_valid = 1'b1; bus.block_done = 1'b1; bus.byte_in = 8'h12;
    @(posedge clk);
    bus.byte_valid = 1'b0; bus.block_done = 1'b0;
    @(posedge clk);
    check("idle_ignores_strobes", 32'(state_dbg), 32'(ST_IDLE));

    // nominal sector
    build(16'h0200, 8'h08, 16'h0020, 8'd2, 32'h0000_0F00, 32'd2, 8'hAA);
    exp_q.push_back(mk_exp(1, 0, 3'd0, 16'h0200, 8'h08, 16'h0020, 8'd2, 32'h0F00, 32'd2,
                           32'h0000_2020, 32'h0000_3E20, 8'd4));
    drive(32'h0000_2000, 512, 0, 0);
    wait_done("nominal");

    // bad signature
    build(16'h0200, 8'h08, 16'h0020, 8'd2, 32'h0000_0F00, 32'd2, 8'h00);
    exp_q.push_back(mk_exp(0, 1, 3'd4, 16'h0200, 8'h08, 16'h0020, 8'd2, 32'h0F00, 32'd2,
                           32'd0, 32'd0, 8'd2));
    drive(32'h0000_2000, 512, 0, 0);
    wait_done("bad_sig");

    // short block
    build(16'h0200, 8'h08, 16'h0020, 8'd2, 32'h0000_0F00, 32'd2, 8'hAA);
    exp_q.push_back(mk_exp(0, 1, 3'd5, 16'h0200, 8'h08, 16'h0020, 8'd2, 32'h0F00, 32'd2,
                           32'd0, 32'd0, 8'd2));
    drive(32'h0000_2000, 300, 0, 0);
    wait_done("short");

    // one byte too many
    exp_q.push_back(mk_exp(0, 1, 3'd5, 16'h0200, 8'h08, 16'h0020, 8'd2, 32'h0F00, 32'd2,
                           32'd0, 32'd0, 8'd2));
    drive(32'h0000_2000, 513, 0, 0);
    wait_done("overflow");

    // priority: bad bps beats num_fats 0
    build(16'h0400, 8'h08, 16'h0020, 8'd0, 32'h0000_0F00, 32'd2, 8'hAA);
    exp_q.push_back(mk_exp(0, 1, 3'd1, 16'h0400, 8'h08, 16'h0020, 8'd0, 32'h0F00, 32'd2,
                           32'd0, 32'd0, 8'd2));
    drive(32'h0000_2000, 512, 0, 0);
    wait_done("bad_bps");

    // spc not a power of two
    build(16'h0200, 8'h06, 16'h0020, 8'd2, 32'h0000_0F00, 32'd2, 8'hAA);
    exp_q.push_back(mk_exp(0, 1, 3'd2, 16'h0200, 8'h06, 16'h0020, 8'd2, 32'h0F00, 32'd2,
                           32'd0, 32'd0, 8'd2));
    drive(32'h0000_2000, 512, 0, 0);
    wait_done("spc6");

    // spc zero
    build(16'h0200, 8'h00, 16'h0020, 8'd4, 32'h0000_0F00, 32'd2, 8'hAA);
    exp_q.push_back(mk_exp(0, 1, 3'd2, 16'h0200, 8'h00, 16'h0020, 8'd4, 32'h0F00, 32'd2,
                           32'd0, 32'd0, 8'd2));
    drive(32'h0000_2000, 512, 0, 0);
    wait_done("spc0");

    // num_fats 5 beats a bad signature
    build(16'h0200, 8'h08, 16'h0020, 8'd5, 32'h0000_0F00, 32'd2, 8'h00);
    exp_q.push_back(mk_exp(0, 1, 3'd3, 16'h0200, 8'h08, 16'h0020, 8'd5, 32'h0F00, 32'd2,
                           32'd0, 32'd0, 8'd2));
    drive(32'h0000_2000, 512, 0, 0);
    wait_done("nfats5");

    // 32-bit wrap
    build(16'h0200, 8'h01, 16'h0020, 8'd1, 32'h0000_0010, 32'd2, 8'hAA);
    exp_q.push_back(mk_exp(1, 0, 3'd0, 16'h0200, 8'h01, 16'h0020, 8'd1, 32'h0010, 32'd2,
                           32'h0000_0010, 32'h0000_0020, 8'd3));
    drive(32'hFFFF_FFF0, 512, 0, 0);
    wait_done("wrap");

    // upper bounds: spc 0x80, num_fats 4
    build(16'h0200, 8'h80, 16'h0020, 8'd4, 32'h0000_0100, 32'd9, 8'hAA);
    exp_q.push_back(mk_exp(1, 0, 3'd0, 16'h0200, 8'h80, 16'h0020, 8'd4, 32'h0100, 32'd9,
                           32'h0000_0020, 32'h0000_0420, 8'd6));
    drive(32'h0000_0000, 512, 0, 0);
    wait_done("bounds");

    // coincident last byte, start pulses while busy and during DONE
    build(16'h0200, 8'h40, 16'h1000, 8'd4, 32'h0001_2345, 32'd5, 8'hAA);
    exp_q.push_back(mk_exp(1, 0, 3'd0, 16'h0200, 8'h40, 16'h1000, 8'd4, 32'h0001_2345, 32'd5,
                           32'h0000_1100, 32'h0004_9E14, 8'd6));
    drive(32'h0000_0100, 512, 1, 1);
    bus.start = 1'b1;
    @(posedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 40 && neg_cnt < bd_ref + 6; k++) @(posedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    bus.start = 1'b0;
    wait_done("coincide");
    check("start_in_done_ignored", 32'(bus.busy), 32'd0);
    check("start_in_done_state", 32'(state_dbg), 32'(ST_IDLE));

    // reset during COMPUTE
    build(16'h0200, 8'h08, 16'h0020, 8'd4, 32'h0000_0001, 32'd2, 8'hAA);
    drive(32'h0000_2000, 512, 0, 0);
    @(posedge clk);
    check("mid_compute_state", 32'(state_dbg), 32'(ST_COMPUTE));
    rst_n = 1'b0;
    #1 check_reset_state("mid_reset");
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    check("no_done_after_reset", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
